operand_loader: RTL and testbench

OPERAND_LOADER -- requirements
Module: operand_loader

---
 rtl/async_proc_pkg.sv | 13 +
 rtl/operand_loader_if.sv | 29 ++
 rtl/switch_debounce.sv | 55 +++++
 rtl/operand_loader.sv | 95 +++++++++
 tb/tb_operand_loader.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/async_proc_pkg.sv
// Shared types and constants for the operand loader: FSM state encoding,
// operand count and default operand width.
package async_proc_pkg;

  localparam int NUM_OPS        = 4;
  localparam int DATA_W_DEFAULT = 4;

  typedef enum logic {
    COLLECT = 1'b0,
    ISSUE   = 1'b1
  } state_e;

endpackage

// File: rtl/operand_loader_if.sv
// Switch-side inputs and operand-side handshake of the operand loader.
interface operand_loader_if
  import async_proc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
);

  logic [DATA_W-1:0]  data_in;
  logic [NUM_OPS-1:0] load_in;
  logic [DATA_W-1:0]  op0;
  logic [DATA_W-1:0]  op1;
  logic [DATA_W-1:0]  op2;
  logic [DATA_W-1:0]  op3;
  logic [NUM_OPS-1:0] loaded;
  logic               op_valid;
  logic               op_ready;
  logic               drop;

  modport master (
    output data_in, load_in, op_ready,
    input  op0, op1, op2, op3, loaded, op_valid, drop
  );

  modport slave (
    input  data_in, load_in, op_ready,
    output op0, op1, op2, op3, loaded, op_valid, drop
  );

endinterface

// File: rtl/switch_debounce.sv
// One load line: 2-flop synchronizer, stability counter, debounced level
// and a registered rising-edge pulse of the debounced level.
module switch_debounce #(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_in,
  output logic rise
);

  localparam logic [7:0] CNT_LAST = 8'(DB_CYCLES - 1);

  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic       level_q, level_d;
  logic       level_dly_q, level_dly_d;
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d     = raw_in;
    sync2_d     = sync1_q;
    level_d     = level_q;
    level_dly_d = level_q;
    cnt_d       = cnt_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = sync2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      level_q     <= level_d;
      level_dly_q <= level_dly_d;
      cnt_q       <= cnt_d;
    end
  end

  // High for the single cycle after the debounced level goes 0->1.
  assign rise = level_q & ~level_dly_q;

endmodule

// File: rtl/operand_loader.sv
// Collects four operands from debounced load switches and offers them as a
// complete set via a valid/ready handshake; loads during ISSUE are dropped.
module operand_loader
  import async_proc_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEFAULT,
  parameter int DB_CYCLES = 4
) (
  input logic              clk,
  input logic              rst,
  operand_loader_if.slave  bus
);

  logic [NUM_OPS-1:0] load_ev;
  logic [DATA_W-1:0]  data_s1_q, data_s2_q;
  logic [DATA_W-1:0]  op_q [NUM_OPS];
  logic [DATA_W-1:0]  op_d [NUM_OPS];
  logic [NUM_OPS-1:0] loaded_q, loaded_d;
  logic               op_valid_q, op_valid_d;
  logic               drop_q, drop_d;
  state_e             state_q, state_d;

  for (genvar g = 0; g < NUM_OPS; g++) begin : g_db
    switch_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk    (clk),
      .rst    (rst),
      .raw_in (bus.load_in[g]),
      .rise   (load_ev[g])
    );
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    loaded_d   = loaded_q;
    op_valid_d = op_valid_q;
    drop_d     = 1'b0;
    case (state_q)
      COLLECT: begin
        for (int i = 0; i < NUM_OPS; i++) begin
          if (load_ev[i]) begin
            op_d[i]     = data_s2_q;
            loaded_d[i] = 1'b1;
          end
        end
        // Advance only once the full set is already visible on loaded.
        if (loaded_q == '1) begin
          state_d    = ISSUE;
          op_valid_d = 1'b1;
        end
      end
      ISSUE: begin
        drop_d = |load_ev;
        if (bus.op_ready) begin
          state_d    = COLLECT;
          loaded_d   = '0;
          op_valid_d = 1'b0;
        end
      end
      default: begin
        state_d    = COLLECT;
        op_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_s1_q  <= '0;
      data_s2_q  <= '0;
      for (int i = 0; i < NUM_OPS; i++) op_q[i] <= '0;
      loaded_q   <= '0;
      op_valid_q <= 1'b0;
      drop_q     <= 1'b0;
      state_q    <= COLLECT;
    end else begin
      data_s1_q  <= bus.data_in;
      data_s2_q  <= data_s1_q;
      op_q       <= op_d;
      loaded_q   <= loaded_d;
      op_valid_q <= op_valid_d;
      drop_q     <= drop_d;
      state_q    <= state_d;
    end
  end

  assign bus.op0      = op_q[0];
  assign bus.op1      = op_q[1];
  assign bus.op2      = op_q[2];
  assign bus.op3      = op_q[3];
  assign bus.loaded   = loaded_q;
  assign bus.op_valid = op_valid_q;
  assign bus.drop     = drop_q;

endmodule

// File: tb/tb_operand_loader.sv
// Directed bench for operand_loader with DB_CYCLES = 4: load vectors from a
// table plus hand-written glitch, drop, handshake and reset sequences.
module tb_operand_loader;

  localparam int DATA_W    = 4;
  localparam int DB_CYCLES = 4;

  typedef struct {
    logic [3:0]  data;
    logic [3:0]  load;
    logic [3:0]  exp_loaded;
    logic [15:0] exp_ops;
    logic        exp_valid;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  operand_loader_if #(.DATA_W(DATA_W)) bus ();

  operand_loader #(.DATA_W(DATA_W), .DB_CYCLES(DB_CYCLES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic edges(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    end
  endtask

  function automatic int ops_word();
    return int'({bus.op3, bus.op2, bus.op1, bus.op0});
  endfunction

  // Step the load lines, check capture on edge DB_CYCLES+3 and valid one edge
  // later, then release the switches and let the levels settle low.
  task automatic apply_vec(input string name, input vec_t v);
    bus.data_in = v.data;
    bus.load_in = v.load;
    edges(DB_CYCLES + 3);
    check({name, "_loaded"}, int'(bus.loaded), int'(v.exp_loaded));
    check({name, "_ops"}, ops_word(), int'(v.exp_ops));
    check({name, "_valid_pre"}, int'(bus.op_valid), 0);
    edges(1);
    check({name, "_valid"}, int'(bus.op_valid), int'(v.exp_valid));
    bus.load_in = 4'b0000;
    edges(8);
  endtask

  initial begin
    vec_t vecs[4];
    vec_t v;
    int   bad;
    int   dcount;

    vecs[0] = '{4'h3, 4'b0001, 4'b0001, 16'h0003, 1'b0};
    vecs[1] = '{4'h1, 4'b0010, 4'b0011, 16'h0013, 1'b0};
    vecs[2] = '{4'h4, 4'b0100, 4'b0111, 16'h0413, 1'b0};
    vecs[3] = '{4'h1, 4'b1000, 4'b1111, 16'h1413, 1'b1};

    rst          = 1'b1;
    bus.data_in  = '0;
    bus.load_in  = '0;
    bus.op_ready = 1'b0;
    edges(3);
    check("rst_ops", ops_word(), 0);
    check("rst_loaded", int'(bus.loaded), 0);
    check("rst_valid", int'(bus.op_valid), 0);
    check("rst_drop", int'(bus.drop), 0);

    // Latency of a clean step on line 0
    rst = 1'b0;
    bus.data_in = 4'h5;
    edges(3);
    bus.load_in = 4'b0001;
    edges(DB_CYCLES + 2);
    check("lat_early_loaded", int'(bus.loaded), 0);
    check("lat_early_op0", int'(bus.op0), 0);
    edges(1);
    check("lat_loaded", int'(bus.loaded), 1);
    check("lat_op0", int'(bus.op0), 5);
    bus.load_in = 4'b0000;
    edges(8);
    check("fall_no_event", int'(bus.loaded), 1);

    // Two-cycle glitch on line 2
    bus.load_in = 4'b0100;
    edges(2);
    bus.load_in = 4'b0000;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      edges(1);
      if (bus.drop !== 1'b0 || bus.loaded !== 4'b0001) bad++;
    end
    check("glitch_ignored", bad, 0);

    for (int i = 0; i < 4; i++) apply_vec($sformatf("vec%0d", i), vecs[i]);

    bad = 0;
    for (int i = 0; i < 5; i++) begin
      edges(1);
      if (ops_word() != 'h1413 || bus.loaded !== 4'b1111 ||
          bus.op_valid !== 1'b1 || bus.drop !== 1'b0) bad++;
    end
    check("issue_hold", bad, 0);

    // Load during ISSUE is dropped with a single pulse
    bus.data_in = 4'hF;
    bus.load_in = 4'b0010;
    dcount = 0;
    for (int i = 0; i < 12; i++) begin
      edges(1);
      if (bus.drop === 1'b1) dcount++;
    end
    check("issue_drop_count", dcount, 1);
    check("issue_drop_ops", ops_word(), 'h1413);
    check("issue_drop_loaded", int'(bus.loaded), 'hF);
    bus.load_in = 4'b0000;
    edges(8);
    check("issue_still_valid", int'(bus.op_valid), 1);

    // Accept the set
    bus.op_ready = 1'b1;
    edges(1);
    bus.op_ready = 1'b0;
    check("accept_valid", int'(bus.op_valid), 0);
    check("accept_loaded", int'(bus.loaded), 0);
    check("accept_ops", ops_word(), 'h1413);

    v = '{4'hA, 4'b1111, 4'b1111, 16'hAAAA, 1'b1};
    apply_vec("all_four", v);

    // Load event coinciding with the accepting handshake
    bus.data_in = 4'h7;
    bus.load_in = 4'b0001;
    edges(DB_CYCLES + 2);
    bus.op_ready = 1'b1;
    edges(1);
    bus.op_ready = 1'b0;
    check("collide_drop", int'(bus.drop), 1);
    check("collide_loaded", int'(bus.loaded), 0);
    check("collide_valid", int'(bus.op_valid), 0);
    check("collide_ops", ops_word(), 'hAAAA);
    edges(1);
    check("collide_drop_one", int'(bus.drop), 0);
    check("collide_loaded_after", int'(bus.loaded), 0);
    bus.load_in = 4'b0000;
    edges(8);

    v = '{4'h6, 4'b1111, 4'b1111, 16'h6666, 1'b1};
    apply_vec("refill", v);

    // Reset while a set is pending
    rst = 1'b1;
    edges(1);
    rst = 1'b0;
    check("rst_issue_valid", int'(bus.op_valid), 0);
    check("rst_issue_loaded", int'(bus.loaded), 0);
    check("rst_issue_ops", ops_word(), 0);
    edges(4);
    check("rst_issue_stays", int'(bus.op_valid), 0);

    // Switch held high through reset release loads exactly once
    bus.data_in = 4'h9;
    bus.load_in = 4'b0100;
    rst = 1'b1;
    edges(2);
    rst = 1'b0;
    edges(DB_CYCLES + 2);
    check("held_early", int'(bus.loaded), 0);
    edges(1);
    check("held_loaded", int'(bus.loaded), 'h4);
    check("held_ops", ops_word(), 'h0900);
    bus.load_in = 4'b0000;
    edges(8);
    check("held_once", int'(bus.loaded), 'h4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
